// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous 32-bit FIFO: issues reads, absorbs the one-cycle
// read latency in a skid buffer and presents a valid/ready stream. Optional: FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int unsigned DW         = 32,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy,
  output logic [2:0]    level
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [31:0]   xfer_cnt,
  output logic          underrun_err
`endif
);

  localparam int unsigned PW = (SKID_DEPTH > 2) ? 2 : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem_q [SKID_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [2:0]      level_q;
  logic            inflight_q;
  logic            pop;
  logic [3:0]      occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop     = m_valid & m_ready;
  assign occ     = {1'b0, level_q} + {3'b000, inflight_q};
  // Reserve a slot for every word already requested; a same-cycle pop frees one.
  assign fifo_rd = ~rst & en & ~fifo_empty & ((occ - {3'b000, pop}) < 4'(SKID_DEPTH));
  assign m_valid = (level_q != 3'd0);
  assign m_data  = m_valid ? mem_q[head_q] : '0;
  assign level   = level_q;
  assign busy    = (state_q != StIdle) | (occ != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd;
      if (inflight_q) tail_q <= ptr_inc(tail_q);
      if (pop)        head_q <= ptr_inc(head_q);
      level_q    <= level_q + {2'b00, inflight_q} - {2'b00, pop};
    end
  end

  // Storage needs no reset: entries are only visible once level counts them.
  always_ff @(posedge clk) begin
    if (!rst && inflight_q) mem_q[tail_q] <= fifo_dout;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = (occ != 4'd0) ? StDrain : StIdle;
      StDrain: begin
        if (en)                 state_d = StRun;
        else if (occ == 4'd0)   state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] xfer_cnt_q;
  logic        underrun_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q     <= '0;
      underrun_err_q <= 1'b0;
    end else begin
      if (pop)                  xfer_cnt_q     <= xfer_cnt_q + 32'd1;
      if (fifo_rd & fifo_empty) underrun_err_q <= 1'b1;
    end
  end

  assign xfer_cnt     = xfer_cnt_q;
  assign underrun_err = underrun_err_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and random bench for fifo_stream_reader; a behavioural FIFO and an in-order
// scoreboard queue stand in for the source and the expected output stream.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst, en, fifo_empty, fifo_rd, m_valid, m_ready, busy;
  logic [31:0] fifo_dout, m_data;
  logic [2:0]  level;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] xfer_cnt;
  logic        underrun_err;
`endif

  fifo_stream_reader #(.DW(32), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .level(level)
`ifdef FIFO_STREAM_READER_CNT_EN
    , .xfer_cnt(xfer_cnt), .underrun_err(underrun_err)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] fmem [2048];
  int          wr_cnt = 0, rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  logic [31:0] expq [$];
  int          total = 0, bad = 0;
  int          nrd = 0, npop = 0, model_cnt = 0, max_level = 0;
  logic        last_rd, last_pop;
  logic [31:0] last_data;
  int          first_rd, last_rd_i, first_pop, last_pop_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] w);
    if (wr_cnt < 2048) begin
      fmem[wr_cnt] = w;
      wr_cnt++;
    end
  endtask

  // One clock: sample at mid-low phase, then model the FIFO's registered read after the edge.
  task automatic cyc();
    logic rd, pv;
    logic [31:0] d;
    #1;
    rd = fifo_rd;
    pv = m_valid & m_ready;
    d  = m_data;
    if (rd && fifo_empty) chk("rd_while_empty", 32'(rd), 32'd0);
    if (int'(level) > max_level) max_level = int'(level);
    if (pv === 1'b1) begin
      npop++;
      model_cnt++;
      last_data = d;
      if (expq.size() == 0) chk("pop_without_word", 32'd1, 32'd0);
      else                  chk("data_order", d, expq.pop_front());
    end
    if (rd === 1'b1) nrd++;
    last_rd  = (rd === 1'b1);
    last_pop = (pv === 1'b1);
    @(posedge clk);
    #1;
    if (last_rd) begin
      fifo_dout = fmem[rd_cnt];
      expq.push_back(fmem[rd_cnt]);
      rd_cnt++;
    end else begin
      fifo_dout = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic flush_model();
    rd_cnt = wr_cnt;
    expq.delete();
    model_cnt = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    cyc();
    cyc();
    flush_model();
    rst = 1'b0;
  endtask

  task automatic track(input int n, input bit toggle);
    first_rd = -1; last_rd_i = -1; first_pop = -1; last_pop_i = -1;
    for (int i = 0; i < n; i++) begin
      if (toggle) m_ready = (i % 2 == 0);
      cyc();
      if (last_rd)  begin if (first_rd < 0)  first_rd = i;  last_rd_i = i;  end
      if (last_pop) begin if (first_pop < 0) first_pop = i; last_pop_i = i; end
    end
  endtask

  initial begin
    int rd0, pop0;
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_dout = '0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  m_data,       32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_level",   32'(level),   32'd0);
    flush_model();
    rst = 1'b0;

    // Enabled against an empty FIFO: running but idle-looking.
    en = 1'b1;
    repeat (5) cyc();
    chk("empty_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("empty_m_valid", 32'(m_valid), 32'd0);
    chk("empty_level",   32'(level),   32'd0);
    chk("empty_busy",    32'(busy),    32'd1);

    // Full-throughput stream.
    m_ready = 1'b1;
    rd0 = nrd; pop0 = npop;
    push(100); push(150); push(10); push(15);
    track(10, 1'b0);
    chk("tp_rd_count",   32'(nrd - rd0),             32'd4);
    chk("tp_rd_span",    32'(last_rd_i - first_rd),  32'd3);
    chk("tp_latency",    32'(first_pop - first_rd),  32'd2);
    chk("tp_pop_count",  32'(npop - pop0),           32'd4);
    chk("tp_pop_span",   32'(last_pop_i - first_pop), 32'd3);

    // Backpressure: two reads fill the buffer, then hold.
    reset_dut();
    rd0 = nrd; pop0 = npop;
    push(100); push(150); push(10); push(15);
    en = 1'b1;
    repeat (6) cyc();
    chk("bp_rd_count", 32'(nrd - rd0), 32'd2);
    chk("bp_level",    32'(level),     32'd2);
    chk("bp_m_valid",  32'(m_valid),   32'd1);
    chk("bp_m_data",   m_data,         32'd100);
    m_ready = 1'b1;
    track(8, 1'b0);
    chk("bp_pop_count", 32'(npop - pop0),            32'd4);
    chk("bp_first_pop", 32'(first_pop),              32'd0);
    chk("bp_pop_span",  32'(last_pop_i - first_pop), 32'd3);

    // Alternating ready over a 16-word stream.
    reset_dut();
    max_level = 0; pop0 = npop;
    for (int w = 1; w <= 16; w++) push(32'(w));
    en = 1'b1;
    track(60, 1'b1);
    chk("alt_pop_count", 32'(npop - pop0),          32'd16);
    chk("alt_max_level", 32'(max_level <= 2),       32'd1);
    chk("alt_drained",   32'(expq.size()),          32'd0);

    // Enable drops right after the read of 150 is issued.
    reset_dut();
    pop0 = npop;
    push(100); push(150); push(10); push(15);
    en = 1'b1; m_ready = 1'b1;
    cyc();
    cyc();
    chk("drop_second_rd", 32'(last_rd), 32'd1);
    en = 1'b0;
    rd0 = nrd;
    chk("drop_busy", 32'(busy), 32'd1);
    repeat (6) cyc();
    chk("drop_no_more_rd", 32'(nrd - rd0),  32'd0);
    chk("drop_pop_count",  32'(npop - pop0), 32'd2);
    chk("drop_last_word",  last_data,        32'd150);
    chk("drop_idle_busy",  32'(busy),        32'd0);
    chk("drop_idle_level", 32'(level),       32'd0);

    // Reset while the buffer is full.
    reset_dut();
    push(7); push(8); push(9); push(10);
    en = 1'b1;
    repeat (5) cyc();
    chk("mid_level_full", 32'(level), 32'd2);
    rst = 1'b1; en = 1'b0;
    cyc();
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_level",   32'(level),   32'd0);
    flush_model();
    rst = 1'b0;
`ifdef FIFO_STREAM_READER_CNT_EN
    chk("cnt_after_rst", xfer_cnt, 32'd0);
    push(1); push(2); push(3);
    en = 1'b1; m_ready = 1'b1;
    repeat (8) cyc();
    chk("cnt_three_pops", xfer_cnt, 32'd3);
    chk("underrun_clear", 32'(underrun_err), 32'd0);
`endif

    // Random traffic against the scoreboard.
    reset_dut();
    max_level = 0;
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) push($urandom);
      cyc();
    end
    en = 1'b1; m_ready = 1'b1;
    repeat (20) cyc();
    chk("rnd_drained",   32'(expq.size()),    32'd0);
    chk("rnd_fifo_empty", 32'(fifo_empty),    32'd1);
    chk("rnd_level",     32'(level),          32'd0);
    chk("rnd_max_level", 32'(max_level <= 2), 32'd1);
`ifdef FIFO_STREAM_READER_CNT_EN
    chk("rnd_xfer_cnt",  xfer_cnt,            32'(model_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the team's synchronous 32-bit FIFO.
- Drives the FIFO's rd strobe from its empty flag.
- Absorbs the FIFO's one-cycle registered read latency in a small internal skid buffer.
- Presents the words on a valid/ready stream, sustaining one word per cycle when the FIFO is non-empty and the sink is ready.

Parameters:
- DW, 32, data width; matches the FIFO word.
- SKID_DEPTH, 2, internal buffer entries. Legal values 2..4; 2 is sufficient for full throughput.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  read enable; 0 stops new FIFO reads
- fifo_empty  in  1  FIFO empty flag, sampled combinationally
- fifo_rd  out  1  FIFO read strobe
- fifo_dout  in  DW  FIFO data; valid the cycle after fifo_rd=1
- m_valid  out  1  output word valid
- m_ready  in  1  sink ready
- m_data  out  DW  output word (head of skid buffer)
- busy  out  1  1 when a read is in flight or the buffer is non-empty
- level  out  3  skid buffer occupancy, 0..SKID_DEPTH

Behaviour:
- Reset values:
  - fifo_rd=0, m_valid=0, m_data=0, busy=0, level=0.
  - In-flight flag cleared; buffer pointers cleared; state=IDLE.
  - Reset mid-operation discards buffered and in-flight words. A fifo_dout arriving the cycle after reset is ignored.
- Terms:
  - inflight: registered copy of fifo_rd. It is 1 in the cycle fifo_dout carries the requested word.
  - pop: m_valid & m_ready.
  - occ: level + inflight.
- fifo_rd is combinational: en & ~fifo_empty & ((occ - pop) < SKID_DEPTH). It never asserts while fifo_empty=1.
- Capture: when inflight=1, fifo_dout is written into the buffer tail that cycle.
- Capture and pop in the same cycle are legal:
  - level is unchanged.
  - With level=0, the captured word becomes visible on m_data the next cycle. Latency from fifo_rd to m_valid is 2 cycles.
- m_valid = (level != 0). m_data is the head entry, held stable while m_valid=1 and m_ready=0.
- Ordering is strict FIFO. No word is dropped or duplicated. Buffer pointers wrap modulo SKID_DEPTH.
- Throughput: with fifo_empty=0 and m_ready=1 held, fifo_rd=1 and pop=1 every cycle after the 2-cycle fill.
- Backpressure: m_ready=0 with buffer full causes fifo_rd=0. No overflow under any input sequence.
- States, registered:
  - IDLE: en=0 and occ=0. Goes to RUN when en=1.
  - RUN: reads as above. Goes to DRAIN when en=0 and occ>0; goes to IDLE when en=0 and occ=0.
  - DRAIN: no new reads; the in-flight word is still captured; the buffer empties via pops. Goes to IDLE when occ=0 and en=0; goes to RUN when en=1.
- busy = (state != IDLE) | (occ != 0).
- en drop with inflight=1: that word is captured and delivered; no word is lost.

Optional Feature:
- FIFO_STREAM_READER_CNT_EN:
  - Defined: adds output port xfer_cnt [31:0].
  - xfer_cnt increments on every pop and wraps from 0xFFFFFFFF to 0; reset value 0.
  - Adds a sticky output underrun_err (1 bit), set if fifo_rd=1 while fifo_empty=1. Cleared only by rst.
- Not defined: neither port exists and no counter logic is built.

Test Plan:
- Reset, then en=1 with fifo_empty=1 for 5 cycles -> fifo_rd=0, m_valid=0, level=0, busy=1 (state RUN).
- FIFO preloaded with 100,150,10,15, m_ready=1, en=1 -> fifo_rd high 4 consecutive cycles; m_data 100,150,10,15 on 4 consecutive cycles starting 2 cycles after the first fifo_rd.
- Same preload, m_ready=0 -> exactly 2 fifo_rd pulses, level=2, m_data=100 stable. Then m_ready=1 -> 100,150,10,15 in order, no gaps after the first.
- m_ready toggled 1,0,1,0 over a 16-word stream 1..16 -> output sequence 1..16 exact; level never exceeds 2.
- en dropped the cycle fifo_rd=1 for word 150 -> 150 still delivered; no further fifo_rd; state DRAIN then IDLE once level=0 and busy=0.
- rst asserted with level=2 -> next cycle m_valid=0, level=0. With FIFO_STREAM_READER_CNT_EN, xfer_cnt=0; after 3 pops xfer_cnt=3.
